// File: rtl/universal_register.sv
// universal_register: N-bit register with load, shift, rotate and up/down count modes
module universal_register #(
  parameter int N = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clear,
  input  logic         enable,
  input  logic [2:0]   mode,
  input  logic         serial_in,
  input  logic [N-1:0] data_input,
  output logic [N-1:0] data_output,
  output logic         shift_out,
  output logic         wrap,
  output logic         zero
);
  logic [N-1:0] d_nxt;
  logic         so_nxt;
  logic         w_nxt;
  always_comb begin
    d_nxt  = data_output;
    so_nxt = shift_out;
    w_nxt  = 1'b0;
    case (mode)
      3'b001: d_nxt = data_input;
      3'b010: begin
        d_nxt  = {data_output[N-2:0], serial_in};
        so_nxt = data_output[N-1];
      end
      3'b011: begin
        d_nxt  = {serial_in, data_output[N-1:1]};
        so_nxt = data_output[0];
      end
      3'b100: begin
        d_nxt  = {data_output[N-2:0], data_output[N-1]};
        so_nxt = data_output[N-1];
      end
      3'b101: begin
        d_nxt  = {data_output[0], data_output[N-1:1]};
        so_nxt = data_output[0];
      end
      3'b110: begin
        d_nxt = data_output + N'(1);
        w_nxt = &data_output;
      end
      3'b111: begin
        d_nxt = data_output - N'(1);
        w_nxt = ~|data_output;
      end
      default: ;
    endcase
  end
  // wrap is a pulse: any edge that does not count across the boundary drops it
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      data_output <= '0;
      shift_out   <= 1'b0;
      wrap        <= 1'b0;
    end else if (clear) begin
      data_output <= '0;
      shift_out   <= 1'b0;
      wrap        <= 1'b0;
    end else if (enable) begin
      data_output <= d_nxt;
      shift_out   <= so_nxt;
      wrap        <= w_nxt;
    end else begin
      wrap        <= 1'b0;
    end
  assign zero = ~|data_output;
endmodule

// File: tb/tb_universal_register.sv
// tb_universal_register: directed checks on N=8 plus a model-checked random stream on N=2 and N=16
module tb_universal_register;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        clear = 1'b0;
  logic        enable = 1'b0;
  logic [2:0]  mode = 3'b000;
  logic        serial_in = 1'b0;
  logic [7:0]  din8 = '0;
  logic [1:0]  din2 = '0;
  logic [15:0] din16 = '0;
  logic [7:0]  q8;
  logic [1:0]  q2;
  logic [15:0] q16;
  logic        so8, so2, so16, w8, w2, w16, z8, z2, z16;
  int          n_err = 0;
  int          n_chk = 0;

  always #5 clk = ~clk;

  universal_register #(.N(8)) dut8 (
    .clk(clk), .reset(reset), .clear(clear), .enable(enable), .mode(mode),
    .serial_in(serial_in), .data_input(din8), .data_output(q8),
    .shift_out(so8), .wrap(w8), .zero(z8)
  );
  universal_register #(.N(2)) dut2 (
    .clk(clk), .reset(reset), .clear(clear), .enable(enable), .mode(mode),
    .serial_in(serial_in), .data_input(din2), .data_output(q2),
    .shift_out(so2), .wrap(w2), .zero(z2)
  );
  universal_register #(.N(16)) dut16 (
    .clk(clk), .reset(reset), .clear(clear), .enable(enable), .mode(mode),
    .serial_in(serial_in), .data_input(din16), .data_output(q16),
    .shift_out(so16), .wrap(w16), .zero(z16)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic op(input logic [2:0] m, input logic s, input logic [7:0] d);
    enable = 1'b1;
    mode = m;
    serial_in = s;
    din8 = d;
    step();
  endtask

  // arithmetic reference written with shifts/masks on an int, independent of bit slicing
  task automatic model(input int w, input logic [15:0] din, inout int d, inout logic so, output logic wr);
    int unsigned mask, msb, lsb;
    mask = (32'd1 << w) - 1;
    msb = (d >> (w - 1)) & 1;
    lsb = d & 1;
    wr = 1'b0;
    if (clear) begin
      d = 0;
      so = 1'b0;
    end else if (enable) begin
      case (mode)
        3'd1: d = din & mask;
        3'd2: begin so = msb[0]; d = ((d << 1) | serial_in) & mask; end
        3'd3: begin so = lsb[0]; d = (d >> 1) | (int'(serial_in) << (w - 1)); end
        3'd4: begin so = msb[0]; d = ((d << 1) | msb) & mask; end
        3'd5: begin so = lsb[0]; d = (d >> 1) | (lsb << (w - 1)); end
        3'd6: begin wr = (d == mask); d = (d + 1) & mask; end
        3'd7: begin wr = (d == 0); d = (d + mask) & mask; end
        default: ;
      endcase
    end
  endtask

  initial begin
    int          m2, m16;
    logic        s2, s16, r2, r16;
    repeat (2) step();
    check("rst_q", q8, 8'h00);
    check("rst_so", so8, 1'b0);
    check("rst_wrap", w8, 1'b0);
    check("rst_zero", z8, 1'b1);
    reset = 1'b0;
    op(3'b001, 1'b0, 8'hA5);
    check("load_a5", q8, 8'hA5);
    check("load_zero", z8, 1'b0);
    op(3'b010, 1'b1, 8'h00);
    check("shl_q", q8, 8'h4B);
    check("shl_so", so8, 1'b1);
    op(3'b011, 1'b0, 8'h00);
    check("shr_q", q8, 8'h25);
    check("shr_so", so8, 1'b1);
    op(3'b011, 1'b1, 8'h00);
    check("shr2_q", q8, 8'h92);
    check("shr2_so", so8, 1'b1);
    op(3'b011, 1'b0, 8'h00);
    check("shr3_so", so8, 1'b0);
    op(3'b001, 1'b0, 8'h81);
    check("load_keeps_so", so8, 1'b0);
    op(3'b100, 1'b0, 8'h00);
    check("rol_q", q8, 8'h03);
    check("rol_so", so8, 1'b1);
    op(3'b101, 1'b0, 8'h00);
    check("ror1_q", q8, 8'h81);
    check("ror1_so", so8, 1'b1);
    op(3'b101, 1'b0, 8'h00);
    check("ror2_q", q8, 8'hC0);
    check("ror2_so", so8, 1'b1);
    op(3'b101, 1'b1, 8'h00);
    check("ror3_q", q8, 8'h60);
    check("ror3_so", so8, 1'b0);
    op(3'b001, 1'b0, 8'hFE);
    op(3'b110, 1'b0, 8'h00);
    check("up1_q", q8, 8'hFF);
    check("up1_wrap", w8, 1'b0);
    op(3'b110, 1'b0, 8'h00);
    check("up2_q", q8, 8'h00);
    check("up2_wrap", w8, 1'b1);
    check("up2_zero", z8, 1'b1);
    op(3'b111, 1'b0, 8'h00);
    check("dn_q", q8, 8'hFF);
    check("dn_wrap", w8, 1'b1);
    op(3'b110, 1'b0, 8'h00);
    check("b2b_wrap", w8, 1'b1);
    op(3'b000, 1'b1, 8'h77);
    check("hold_q", q8, 8'h00);
    check("hold_wrap", w8, 1'b0);
    op(3'b111, 1'b0, 8'h00);
    op(3'b111, 1'b0, 8'h00);
    check("dn_nowrap_q", q8, 8'hFE);
    check("dn_nowrap", w8, 1'b0);
    op(3'b001, 1'b0, 8'h3C);
    op(3'b010, 1'b1, 8'h00);
    check("pre_en_so", so8, 1'b0);
    op(3'b001, 1'b0, 8'h3C);
    op(3'b100, 1'b0, 8'h00);
    check("pre_en_q", q8, 8'h78);
    enable = 1'b0;
    mode = 3'b110;
    for (int i = 0; i < 5; i++) begin
      step();
      check("en0_q", q8, 8'h78);
      check("en0_wrap", w8, 1'b0);
    end
    check("en0_so", so8, 1'b0);
    op(3'b001, 1'b0, 8'hFF);
    enable = 1'b0;
    mode = 3'b110;
    step();
    check("en0_nowrap", w8, 1'b0);
    check("en0_ff", q8, 8'hFF);
    op(3'b100, 1'b0, 8'h00);
    check("so_before_clr", so8, 1'b1);
    clear = 1'b1;
    op(3'b001, 1'b0, 8'h55);
    check("clr_q", q8, 8'h00);
    check("clr_so", so8, 1'b0);
    check("clr_zero", z8, 1'b1);
    clear = 1'b0;
    op(3'b111, 1'b0, 8'h00);
    check("pre_clr_wrap", w8, 1'b1);
    clear = 1'b1;
    op(3'b111, 1'b0, 8'h00);
    check("clr_wrap", w8, 1'b0);
    check("clr_dn_q", q8, 8'h00);
    clear = 1'b0;
    op(3'b001, 1'b0, 8'h5A);
    op(3'b010, 1'b1, 8'h00);
    #2;
    reset = 1'b1;
    #1;
    check("arst_q", q8, 8'h00);
    check("arst_so", so8, 1'b0);
    check("arst_zero", z8, 1'b1);
    op(3'b001, 1'b0, 8'h77);
    check("rst_ign_q", q8, 8'h00);
    reset = 1'b0;
    op(3'b001, 1'b0, 8'h77);
    check("post_rst_load", q8, 8'h77);
    op(3'b110, 1'b0, 8'h00);
    op(3'b110, 1'b0, 8'h00);
    check("cnt_q", q8, 8'h79);
    #3;
    reset = 1'b1;
    #1;
    reset = 1'b0;
    op(3'b000, 1'b0, 8'h00);
    check("cnt_rst_q", q8, 8'h00);
    reset = 1'b1;
    step();
    reset = 1'b0;
    m2 = 0;
    m16 = 0;
    s2 = 1'b0;
    s16 = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      clear = ($urandom_range(0, 15) == 0);
      enable = ($urandom_range(0, 7) != 0);
      mode = 3'($urandom_range(0, 7));
      serial_in = 1'($urandom_range(0, 1));
      din2 = 2'($urandom);
      din16 = 16'($urandom);
      model(2, {14'd0, din2}, m2, s2, r2);
      model(16, din16, m16, s16, r16);
      step();
      check("n2_q", q2, m2);
      check("n2_so", so2, s2);
      check("n2_wrap", w2, r2);
      check("n2_zero", z2, m2 == 0);
      check("n16_q", q16, m16);
      check("n16_so", so16, s16);
      check("n16_wrap", w16, r16);
      check("n16_zero", z16, m16 == 0);
    end
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
